// File: rtl/bitcell_array_ctrl.sv
// Sequencer and two-port round-robin arbiter for a WORDS x DATA_W NAND-latch bitcell array.
// Holds select/op/data for the settle window, checks arr_valid, then returns a one-cycle ack.
module bitcell_array_ctrl #(
  parameter int unsigned WORDS      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [WORDS-1:0]  row_sel,
  output logic              op,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata,
  input  logic              arr_valid
);

  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, op_q, op_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, arr_wdata_q, arr_wdata_d;
  logic [WORDS-1:0]    row_sel_q, row_sel_d;

  logic                pick1;
  logic [ADDR_W-1:0]   addr_sel;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1    = req1 && (!req0 || !rr_last_q);
  assign addr_sel = pick1 ? addr1 : addr0;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    perr_d      = perr_q;
    rbuf_d      = rbuf_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    row_sel_d   = row_sel_q;
    op_d        = op_q;
    arr_wdata_d = arr_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt_d     = pick1;
          rr_last_d = pick1;
          we_d      = pick1 ? we1 : we0;
          addr_d    = addr_sel;
          wdata_d   = pick1 ? wdata1 : wdata0;
          perr_d    = (32'(addr_sel) >= WORDS);
          state_d   = perr_d ? StResp : StSetup;
        end
      end
      StSetup: begin
        row_sel_d   = WORDS'(1) << addr_q;
        op_d        = we_q;
        arr_wdata_d = wdata_q;
        cnt_d       = CntW'(SETTLE_CYC - 1);
        tmo_d       = '0;
        state_d     = StAccess;
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (arr_valid) begin
          if (!we_q) rbuf_d = arr_rdata;
          perr_d  = 1'b0;
          state_d = StResp;
        end else if (tmo_q == TmoW'(TIMEOUT)) begin
          perr_d  = 1'b1;
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResp: begin
        row_sel_d = '0;
        op_d      = 1'b0;
        ack0_d    = !gnt_q;
        ack1_d    = gnt_q;
        err_d     = perr_q;
        if (!perr_q && !we_q) rdata_d = rbuf_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_last_q   <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      perr_q      <= 1'b0;
      rbuf_q      <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      row_sel_q   <= '0;
      op_q        <= 1'b0;
      arr_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      perr_q      <= perr_d;
      rbuf_q      <= rbuf_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      row_sel_q   <= row_sel_d;
      op_q        <= op_d;
      arr_wdata_q <= arr_wdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign row_sel   = row_sel_q;
  assign op        = op_q;
  assign arr_wdata = arr_wdata_q;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Scoreboard bench for bitcell_array_ctrl: a behavioural array model answers the controller,
// expected acks are queued at issue time and checked when an ack pulse appears.
module tb_bitcell_array_ctrl;
  localparam int unsigned WORDS      = 16;
  localparam int unsigned ADDR_W     = 5;  // wide enough to express out-of-range rows
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned TIMEOUT    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1, err, op, arr_valid;
  logic [DATA_W-1:0] rdata, arr_wdata, arr_rdata;
  logic [WORDS-1:0]  row_sel;

  always #5 clk = ~clk;

  bitcell_array_ctrl #(
    .WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err), .row_sel(row_sel), .op(op), .arr_wdata(arr_wdata),
    .arr_rdata(arr_rdata), .arr_valid(arr_valid)
  );

  // Array model
  logic [DATA_W-1:0] mem [WORDS];
  logic              arr_ok;

  function automatic int sel_idx(input logic [WORDS-1:0] s);
    for (int i = 0; i < int'(WORDS); i++) if (s[i]) return i;
    return 0;
  endfunction

  assign arr_rdata = mem[sel_idx(row_sel)];
  assign arr_valid = arr_ok && (row_sel != '0);

  always @(posedge clk) if (row_sel != '0 && op) mem[sel_idx(row_sel)] <= arr_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int                id;
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                ack_cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: structural invariants every cycle, scoreboard pop on each ack.
  logic [WORDS-1:0]  prev_sel = '0;
  logic              prev_op = 1'b0;
  logic [DATA_W-1:0] prev_wd = '0;
  logic [WORDS-1:0]  seen_sel = '0;
  logic              seen_op = 1'b0;
  int                sel_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    check("row_sel_onehot", 32'($onehot0(row_sel)), 1);
    if (prev_sel != '0 && row_sel == prev_sel) begin
      check("op_stable", op, prev_op);
      check("wdata_stable", arr_wdata, prev_wd);
    end
    if (row_sel != '0) begin
      seen_sel = row_sel;
      seen_op  = op;
      sel_cnt++;
    end
    prev_sel = row_sel;
    prev_op  = op;
    prev_wd  = arr_wdata;
    if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check("spurious_ack", {ack1, ack0}, 0);
      end else begin
        e = sb.pop_front();
        check("ack_id", {ack1, ack0}, (e.id == 1) ? 2 : 1);
        check("err", err, e.err);
        check("rdata", rdata, e.rdata);
        if (e.ack_cyc >= 0) check("latency", cyc, e.ack_cyc);
      end
    end
  end

  task automatic push_exp(input int id, input logic e_err, input logic [DATA_W-1:0] e_rd,
                          input int ack_cyc);
    exp_t e;
    e.id = id; e.err = e_err; e.rdata = e_rd; e.ack_cyc = ack_cyc;
    sb.push_back(e);
  endtask

  task automatic issue(input int id, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input logic e_err,
                       input logic [DATA_W-1:0] e_rd, input int lat);
    bit got = 1'b0;
    @(posedge clk);
    #2;
    push_exp(id, e_err, e_rd, cyc + 1 + lat);
    if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((id == 0 && ack0) || (id == 1 && ack1)) got = 1'b1;
    end
    if (!got) check("ack_timeout", 0, 1);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_ack;
    int s0;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    arr_ok = 1'b1;
    #1;
    check("rst_row_sel", row_sel, 0);
    check("rst_acks", {ack1, ack0}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    do_reset();

    // Write 0xA5 to row 3, then read it back through the other port.
    issue(0, 1'b1, 5'd3, 8'hA5, 1'b0, 8'h00, 4);
    check("wr_row_sel", seen_sel, 16'h0008);
    check("wr_op", seen_op, 1);
    issue(1, 1'b0, 5'd3, 8'h00, 1'b0, 8'hA5, 4);

    // Out-of-range row: immediate error ack, array untouched.
    s0 = sel_cnt;
    issue(0, 1'b0, 5'd20, 8'h00, 1'b1, 8'hA5, 1);
    check("oor_no_select", sel_cnt - s0, 0);

    // arr_valid never rises: timeout error, rdata keeps its last value.
    arr_ok = 1'b0;
    issue(1, 1'b0, 5'd3, 8'h00, 1'b1, 8'hA5, 4 + TIMEOUT);
    arr_ok = 1'b1;

    // Both requesters held high: grants alternate starting with 0 after reset.
    do_reset();
    @(posedge clk);
    #2;
    push_exp(0, 1'b0, 8'h00, -1);
    push_exp(1, 1'b0, 8'h3C, -1);
    push_exp(0, 1'b0, 8'h3C, -1);
    push_exp(1, 1'b0, 8'h3C, -1);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 8'h3C;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd7;
    n_ack = 0;
    for (int i = 0; i < 200 && n_ack < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) n_ack++;
    end
    check("rr_ack_count", n_ack, 4);
    req0 = 1'b0;
    req1 = 1'b0;

    // Reset in the middle of an access: outputs clear at once and no ack follows.
    @(posedge clk);
    #2;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd9; wdata0 = 8'h5A;
    repeat (3) @(posedge clk);
    #3;
    check("pre_abort_sel", row_sel, 16'h0200);
    rst = 1'b1;
    #1;
    check("abort_row_sel", row_sel, 0);
    check("abort_op", op, 0);
    check("abort_wdata", arr_wdata, 0);
    check("abort_acks", {ack1, ack0}, 0);
    check("abort_rdata", rdata, 0);
    check("abort_err", err, 0);
    req0 = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(1, 1'b1, 5'd9, 8'h5A, 1'b0, 8'h00, 4);
    issue(0, 1'b0, 5'd9, 8'h00, 1'b0, 8'h5A, 4);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
